// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl -- memory-sequence game controller.
//
// Each round shows a random nibble pattern (one 4-bit symbol per level),
// then collects the player's symbols and checks them. Sixteen correct
// rounds win the game. Any mismatch loses it.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a new game (honoured only in IDLE/WIN/LOSE)
//   btn_valid  : player symbol strobe, one symbol per high cycle in INPUT
//   btn_code   : player symbol
//   reg_en     : load strobe to the register pair (LOAD and COMMIT only)
//   reg_a      : masked pattern, nibbles 0..level-1
//   reg_b      : player entry (0 during LOAD)
//   show       : pattern display window
//   busy       : game in progress
//   win / lose : game outcome, held until the next start
//   level      : current round 1..16, 0 after reset
module game_seq_ctrl #(
  parameter int          SHOW_CYCLES = 16,
  parameter logic [63:0] LFSR_SEED   = 64'hACE1_0F0F_5A5A_1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        btn_valid,
  input  logic [3:0]  btn_code,
  output logic        reg_en,
  output logic [63:0] reg_a,
  output logic [63:0] reg_b,
  output logic        show,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic [4:0]  level
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHOW, S_INPUT, S_COMMIT, S_CHECK, S_WIN, S_LOSE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [63:0] pat_q, pat_d;
  logic [63:0] entry_q, entry_d;
  logic [4:0]  cursor_q, cursor_d;
  logic [4:0]  level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  // Ones in the nibbles that belong to the active level.
  function automatic logic [63:0] mask_f(input logic [4:0] lvl);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < lvl) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    entry_d  = entry_q;
    cursor_d = cursor_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    // Fibonacci LFSR, taps 64,63,61,60, free-running in every state.
    lfsr_d   = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          pat_d    = lfsr_q;
          level_d  = 5'd1;
          entry_d  = '0;
          cursor_d = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == 16'(SHOW_CYCLES - 1)) begin
          cursor_d = '0;
          state_d  = S_INPUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_INPUT: begin
        if (btn_valid) begin
          entry_d[4*cursor_q[3:0] +: 4] = btn_code;
          cursor_d = cursor_q + 5'd1;
          // The final symbol moves straight to COMMIT so reg_b carries it.
          if (cursor_q + 5'd1 == level_q) state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_CHECK;
      S_CHECK: begin
        if ((pat_q & mask_f(level_q)) != entry_q) begin
          state_d = S_LOSE;
        end else if (level_q == 5'd16) begin
          state_d = S_WIN;
        end else begin
          level_d  = level_q + 5'd1;
          entry_d  = '0;
          cursor_d = '0;
          state_d  = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // cycles the corresponding state occupies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      pat_q    <= '0;
      entry_q  <= '0;
      cursor_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      reg_en   <= 1'b0;
      reg_a    <= '0;
      reg_b    <= '0;
      show     <= 1'b0;
      busy     <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      level    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      pat_q    <= pat_d;
      entry_q  <= entry_d;
      cursor_q <= cursor_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      reg_en   <= (state_d == S_LOAD) || (state_d == S_COMMIT);
      reg_a    <= ((state_d == S_LOAD) || (state_d == S_COMMIT)) ?
                  (pat_d & mask_f(level_d)) : '0;
      reg_b    <= (state_d == S_COMMIT) ? entry_d : '0;
      show     <= (state_d == S_SHOW);
      busy     <= !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
      win      <= (state_d == S_WIN);
      lose     <= (state_d == S_LOSE);
      level    <= level_d;
    end
  end

endmodule

// File: tb/tb_game_seq_ctrl.sv
module tb_game_seq_ctrl;

  localparam int          SHOW = 16;
  localparam logic [63:0] SEED = 64'hACE1_0F0F_5A5A_1234;

  logic        clk, rst_n, start, btn_valid;
  logic [3:0]  btn_code;
  logic        reg_en, show, busy, win, lose;
  logic [63:0] reg_a, reg_b;
  logic [4:0]  level;

  int          vecs, errs;
  logic [63:0] exp_pat;
  logic [63:0] m_lfsr;

  game_seq_ctrl #(.SHOW_CYCLES(SHOW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_valid(btn_valid),
    .btn_code(btn_code), .reg_en(reg_en), .reg_a(reg_a), .reg_b(reg_b),
    .show(show), .busy(busy), .win(win), .lose(lose), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 64,63,61,60, shifted left, feedback into bit 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
  end

  function automatic logic [63:0] mask(input int lvl);
    if (lvl >= 16) return {64{1'b1}};
    return (64'd1 << (4 * lvl)) - 64'd1;
  endfunction

  // Called at a falling edge while in IDLE/WIN/LOSE; returns at the falling
  // edge of the LOAD cycle.
  task automatic do_start();
    start   = 1'b1;
    exp_pat = m_lfsr;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called at the falling edge of a LOAD cycle; returns at the falling edge
  // of the first INPUT cycle.
  task automatic load_show(input int lvl, input bit toggle);
    int nshow;
    logic any_en;
    vecs++;
    if (reg_en !== 1'b1 || reg_a !== (exp_pat & mask(lvl)) || reg_b !== 64'd0) begin
      errs++;
      $display("FAIL load_l%0d: en=%b a=%h b=%h, want en=1 a=%h b=0",
               lvl, reg_en, reg_a, reg_b, exp_pat & mask(lvl));
    end
    vecs++;
    if (level !== 5'(lvl) || busy !== 1'b1 || show !== 1'b0) begin
      errs++;
      $display("FAIL load_state_l%0d: level=%0d busy=%b show=%b, want level=%0d busy=1 show=0",
               lvl, level, busy, show, lvl);
    end
    nshow  = 0;
    any_en = 1'b0;
    for (int i = 0; i < SHOW; i++) begin
      @(negedge clk);
      if (show === 1'b1) nshow++;
      any_en |= reg_en;
      if (toggle) begin
        btn_valid = i[0];
        btn_code  = 4'hF;
      end
    end
    @(negedge clk);
    btn_valid = 1'b0;
    vecs++;
    if (nshow != SHOW || show !== 1'b0 || any_en !== 1'b0) begin
      errs++;
      $display("FAIL show_l%0d: show cycles=%0d show_after=%b en_seen=%b, want %0d/0/0",
               lvl, nshow, show, any_en, SHOW);
    end
  endtask

  // Called at the falling edge of an INPUT cycle; enters lvl symbols (symbol
  // bad is corrupted), checks COMMIT and CHECK, returns in the following state.
  task automatic enter(input int lvl, input int bad);
    logic [63:0] ent;
    ent = '0;
    for (int i = 0; i < lvl; i++) begin
      btn_valid = 1'b1;
      btn_code  = exp_pat[4*i +: 4] ^ ((i == bad) ? 4'h1 : 4'h0);
      ent[4*i +: 4] = btn_code;
      @(negedge clk);
    end
    btn_valid = 1'b0;
    vecs++;
    if (reg_en !== 1'b1 || reg_a !== (exp_pat & mask(lvl)) || reg_b !== ent) begin
      errs++;
      $display("FAIL commit_l%0d: en=%b a=%h b=%h, want en=1 a=%h b=%h",
               lvl, reg_en, reg_a, reg_b, exp_pat & mask(lvl), ent);
    end
    @(negedge clk);
    vecs++;
    if (reg_en !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL check_l%0d: en=%b busy=%b, want en=0 busy=1", lvl, reg_en, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic any;
    rst_n = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 4'h0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({reg_en, show, busy, win, lose, level} !== 10'd0 || reg_a !== 64'd0 || reg_b !== 64'd0) begin
      errs++;
      $display("FAIL reset_outputs: en=%b show=%b busy=%b win=%b lose=%b level=%0d a=%h b=%h, want all 0",
               reg_en, show, busy, win, lose, level, reg_a, reg_b);
    end
    rst_n = 1'b1;
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any |= reg_en | busy | show;
    end
    vecs++;
    if (any !== 1'b0 || level !== 5'd0) begin
      errs++;
      $display("FAIL idle_after_reset: activity=%b level=%0d, want 0/0", any, level);
    end
  endtask

  task automatic test_levels();
    do_start();
    load_show(1, 1'b0);
    enter(1, -1);
    load_show(2, 1'b0);
    enter(2, -1);
  endtask

  task automatic test_lose();
    load_show(3, 1'b0);
    enter(3, 1);
    vecs++;
    if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0) begin
      errs++;
      $display("FAIL lose_flag: lose=%b busy=%b win=%b, want 1/0/0", lose, busy, win);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (lose !== 1'b1 || reg_en !== 1'b0) begin
      errs++;
      $display("FAIL lose_hold: lose=%b en=%b, want 1/0", lose, reg_en);
    end
    do_start();
    vecs++;
    if (lose !== 1'b0 || win !== 1'b0) begin
      errs++;
      $display("FAIL restart_flags: lose=%b win=%b, want 0/0", lose, win);
    end
  endtask

  task automatic test_ignore();
    load_show(1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vecs++;
    if (reg_en !== 1'b0 || level !== 5'd1 || busy !== 1'b1 || show !== 1'b0) begin
      errs++;
      $display("FAIL start_in_input: en=%b level=%0d busy=%b show=%b, want 0/1/1/0",
               reg_en, level, busy, show);
    end
    enter(1, -1);
  endtask

  task automatic test_reset_mid();
    logic any;
    for (int l = 2; l <= 4; l++) begin
      load_show(l, 1'b0);
      enter(l, -1);
    end
    load_show(5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      btn_valid = 1'b1;
      btn_code  = exp_pat[4*i +: 4];
      @(negedge clk);
    end
    btn_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if ({reg_en, show, busy, win, lose, level} !== 10'd0 || reg_a !== 64'd0 || reg_b !== 64'd0) begin
      errs++;
      $display("FAIL reset_mid_input: en=%b show=%b busy=%b win=%b lose=%b level=%0d, want all 0",
               reg_en, show, busy, win, lose, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any |= reg_en | busy | show;
    end
    vecs++;
    if (any !== 1'b0 || level !== 5'd0) begin
      errs++;
      $display("FAIL idle_after_mid_reset: activity=%b level=%0d, want 0/0", any, level);
    end
  endtask

  task automatic test_win();
    logic any;
    do_start();
    for (int l = 1; l <= 16; l++) begin
      load_show(l, 1'b0);
      enter(l, -1);
    end
    vecs++;
    if (win !== 1'b1 || lose !== 1'b0 || busy !== 1'b0 || level !== 5'd16) begin
      errs++;
      $display("FAIL win_flag: win=%b lose=%b busy=%b level=%0d, want 1/0/0/16",
               win, lose, busy, level);
    end
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any |= reg_en | busy;
    end
    vecs++;
    if (any !== 1'b0 || win !== 1'b1) begin
      errs++;
      $display("FAIL win_hold: activity=%b win=%b, want 0/1", any, win);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_levels();
    test_lose();
    test_ignore();
    test_reset_mid();
    test_win();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/game_seq_ctrl.md
GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 16: number of cycles the pattern is displayed per round (range 1..2^16-1).
REQ-002 SHALL have parameter LFSR_SEED, default 64'hACE1_0F0F_5A5A_1234: LFSR reset value; it is nonzero.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a new game.
REQ-006 SHALL have port btn_valid, input, 1 bit: player symbol strobe, one symbol per high cycle.
REQ-007 SHALL have port btn_code, input, 4 bits: player symbol.
REQ-008 SHALL have port reg_en, output, 1 bit: load strobe to the 64-bit register pair.
REQ-009 SHALL have port reg_a, output, 64 bits: masked pattern to the register pair.
REQ-010 SHALL have port reg_b, output, 64 bits: player entry to the register pair.
REQ-011 SHALL have port show, output, 1 bit: pattern display window.
REQ-012 SHALL have port busy, output, 1 bit: game in progress (any state except IDLE/WIN/LOSE).
REQ-013 SHALL have port win, output, 1 bit: game won.
REQ-014 SHALL have port lose, output, 1 bit: game lost.
REQ-015 SHALL have port level, output, 5 bits: current round, 1..16; 0 when idle.

Function
REQ-016 SHALL hold each symbol as a nibble: symbol i occupies bits [4i+3:4i]; level L uses nibbles 0..L-1, and all higher nibbles of reg_a/reg_b are 0.
REQ-017 SHALL advance a 64-bit Fibonacci LFSR (taps 64,63,61,60) every cycle in every state.
REQ-018 SHALL implement FSM states IDLE, LOAD, SHOW, INPUT, COMMIT, CHECK, WIN, LOSE.
REQ-019 IDLE/WIN/LOSE + start=1 SHALL capture the LFSR value as the pattern, set level=1, clear the entry and cursor, and go to LOAD; start SHALL be ignored in all other states.
REQ-020 LOAD SHALL last 1 cycle with reg_en=1, reg_a=masked pattern, reg_b=0, then go to SHOW.
REQ-021 SHOW SHALL assert show for exactly SHOW_CYCLES cycles, then go to INPUT with cursor=0.
REQ-022 INPUT, on btn_valid=1, SHALL write btn_code into entry nibble [cursor] and increment the cursor; when the cursor reaches level, it SHALL go to COMMIT on the next cycle.
REQ-023 btn_valid SHALL be ignored outside INPUT, including during SHOW.
REQ-024 COMMIT SHALL last 1 cycle with reg_en=1, reg_a=masked pattern, reg_b=entry, then go to CHECK.
REQ-025 CHECK SHALL compare the masked pattern with the entry: on mismatch go to LOSE; on match with level=16 go to WIN; on match with level<16, increment level, clear entry and cursor, and go to LOAD.
REQ-026 WIN SHALL hold win=1 and LOSE SHALL hold lose=1 until start; win and lose SHALL never both be 1.
REQ-027 All outputs SHALL be registered, so the state-dependent outputs of a state appear in the cycles that state occupies.
REQ-028 Latency: start sampled at edge N SHALL give reg_en=1 in cycle N+1 and show=1 in cycles N+2..N+1+SHOW_CYCLES.
REQ-029 reg_en SHALL be 0 in every state except LOAD and COMMIT.

Reset
REQ-030 rst_n=0 SHALL immediately set state=IDLE, LFSR=LFSR_SEED, pattern=0, entry=0, cursor=0, and set all outputs to 0 (level=0), regardless of the current state.
REQ-031 After rst_n deasserts, the block SHALL require a new start before any reg_en pulse.

Verification
REQ-032 Reset then start pulse -> reg_en=1 one cycle later with reg_a[63:4]=0 and reg_a[3:0]=LFSR nibble; show high for exactly 16 cycles; level=1.
REQ-033 Level 1: enter the correct nibble -> COMMIT reg_en with reg_b=reg_a, level becomes 2, and a second LOAD pulse shows 2 nibbles.
REQ-034 Level 3: enter a wrong 2nd symbol -> COMMIT after the 3rd symbol, then lose=1, busy=0, win=0; start restarts at level 1.
REQ-035 Play 16 correct rounds -> win=1 after the level-16 CHECK, reg_b=reg_a=full 64-bit pattern, and no further LOAD occurs.
REQ-036 btn_valid toggled during SHOW and start pulsed during INPUT -> entry unchanged and no restart.
REQ-037 rst_n asserted mid-INPUT at level 5 -> all outputs 0 at once; after release, idle until start.
